t5_lsu: RTL and testbench
=========================

# t5_lsu

Load/store unit for the t5 pipeline, directly downstream of the execute (ALU) stage. It consumes the execute-stage opcode, funct3, effective address and lane-replicated store data, and drives a single-outstanding, Wishbone-style data bus. It returns aligned and sign/zero-extended load data to the memory stage. It also produces the `xstb`/`xwre` misalignment status that the ALU/CSR stage uses to update mepc, mcause and mtval.

## Interface
- No parameters; datapath fixed at 32 bits.
- `sclk` in 1: clock.
- `srst` in 1: reset, synchronous, active-high.
- `sena` in 1: pipeline advance enable.
- `xopc` in [6:2]: execute-stage opcode. LOAD = 5'b00000, STORE = 5'b01000.
- `xfn3` in [14:12]: execute-stage funct3.
- `xadr` in 32: effective address.
- `xdat` in 32: store data, already replicated across byte lanes.
- `dwb_adr_o` out [31:2]: word address.
- `dwb_dat_o` out 32: write data.
- `dwb_sel_o` out 4: byte-lane enables.
- `dwb_we_o` out 1: write strobe qualifier.
- `dwb_stb_o` out 1: request valid.
- `dwb_ack_i` in 1: transfer complete.
- `dwb_dat_i` in 32: read data.
- `mlsu` out 32: extended load result.
- `xstb` out 2: {access, misaligned}.
- `xwre` out 1: 1 = last access was a store.
- `lstall` out 1: stall request; the top deasserts `sena` while high.

## Operation
- States are IDLE and BUSY. Reset enters IDLE.
- **Capture in IDLE:**
  - Capture happens only in IDLE, on a cycle with `sena`=1.
  - `mem` = (xopc==LOAD) | (xopc==STORE).
  - `mis` = (xfn3[13:12]==01 & xadr[0]) | (xfn3[13:12]==10 & |xadr[1:0]).
  - `xstb` <= {mem, mem&mis}.
  - `xwre` <= (xopc==STORE) when `mem`; otherwise it holds.
- **Accepted access:** `mem` & !`mis`.
  - State goes to BUSY.
  - `dwb_stb_o` <= 1.
  - `dwb_we_o` <= store.
  - `dwb_adr_o` <= xadr[31:2].
  - `dwb_dat_o` <= xdat.
  - Latch xfn3 and xadr[1:0] for load extraction.
- **Misaligned access:** no bus cycle, state stays IDLE. The exception reaches the CSR logic as `xstb`=2'b11, giving mcause 4 for a load and 6 for a store.
- **Byte lanes (`dwb_sel_o`):**
  - Byte: 4'b0001 << adr[1:0].
  - Half: adr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - funct3 encoding 11 is unused and is treated as word.
- **BUSY:** all bus outputs are held stable until `dwb_ack_i`. Then:
  - `dwb_stb_o` <= 0 and `dwb_we_o` <= 0; `dwb_sel_o` and `dwb_adr_o` may hold.
  - State returns to IDLE.
  - For a load, `mlsu` <= extract(dwb_dat_i).
- **Load extraction:**
  - fn3=000 (LB): sign-extend lane adr[1:0].
  - fn3=100 (LBU): zero-extend lane adr[1:0].
  - fn3=001 (LH): sign-extend half adr[1].
  - fn3=101 (LHU): zero-extend half adr[1].
  - fn3=010 (LW): pass through.
- A store leaves `mlsu` unchanged.
- `sena` is ignored in BUSY; no second request is ever issued while one is outstanding.
- `dwb_ack_i` in IDLE is ignored.

## Timing
- Reset values:
  - `dwb_stb_o`, `dwb_we_o`, `lstall`, `xwre` = 0.
  - `dwb_sel_o` = 4'h0, `dwb_adr_o` = 30'h0, `dwb_dat_o` = 32'h0.
  - `mlsu` = 32'h0, `xstb` = 2'b00.
  - State = IDLE.
- All outputs are registered except `lstall` = (state==BUSY), which is a decode of the state register.
- **Latency:**
  - Capture edge N; `dwb_stb_o` is high from cycle N+1.
  - Ack sampled at edge K: `mlsu` is valid and `lstall` is low from cycle K+1.
  - With zero-wait ack (ack in cycle N+1), the minimum is 2 cycles from capture to result.
- `xstb` is updated on every IDLE+`sena` edge, so a non-memory instruction clears it to 00 one cycle later.
- Reset mid-transaction aborts the request: `dwb_stb_o` drops at the next edge and a late ack is ignored.
- Simultaneous `srst` and `dwb_ack_i`: reset wins and `mlsu` = 0.

## Test plan
- **LW aligned:** xadr=0x100, dwb_dat_i=0xDEADBEEF, ack after 3 wait cycles.
  - Required: stb high 4 cycles, sel=1111, adr=0x40, lstall high 4 cycles.
  - Required: `mlsu`=0xDEADBEEF, `xstb`=10, `xwre`=0.
- **LB/LBU lane 3:** xadr=0x203, dwb_dat_i=0x80123456.
  - Required: LB gives `mlsu`=0xFFFFFF80 with sel=1000; LBU gives 0x00000080.
- **SH upper half:** xadr=0x302, xdat=0xA5A5A5A5, ack in 1 cycle.
  - Required: we=1, sel=1100, dat_o=0xA5A5A5A5, `mlsu` unchanged, `xwre`=1.
- **Misaligned SW:** xadr=0x401.
  - Required: no stb ever, `xstb`=11, `xwre`=1, lstall stays 0.
  - Next: a following ADD instruction clears `xstb` to 00.
- **Reset mid-access:** assert srst while BUSY, then pulse dwb_ack_i 1 cycle later.
  - Required: stb=0, state IDLE, `mlsu`=0, ack ignored.
  - Required: a following LW completes normally.

Source files
------------

// File: rtl/t5_lsu.sv
// t5_lsu: single-outstanding load/store unit with Wishbone-style data bus and misalignment status
module t5_lsu (
    input  logic        sclk,
    input  logic        srst,
    input  logic        sena,
    input  logic [6:2]  xopc,
    input  logic [14:12] xfn3,
    input  logic [31:0] xadr,
    input  logic [31:0] xdat,
    output logic [31:2] dwb_adr_o,
    output logic [31:0] dwb_dat_o,
    output logic [3:0]  dwb_sel_o,
    output logic        dwb_we_o,
    output logic        dwb_stb_o,
    input  logic        dwb_ack_i,
    input  logic [31:0] dwb_dat_i,
    output logic [31:0] mlsu,
    output logic [1:0]  xstb,
    output logic        xwre,
    output logic        lstall
);
    localparam logic [6:2] OPC_LOAD  = 5'b00000;
    localparam logic [6:2] OPC_STORE = 5'b01000;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [14:12] r_fn3;
    logic [1:0]   r_lo;
    logic         w_st;
    logic         w_mem;
    logic         w_mis;
    logic         w_acc;
    logic [3:0]   w_sel;
    logic [31:0]  w_sh;
    logic [15:0]  w_hw;
    logic [31:0]  w_ext;

    // Decode the execute-stage instruction and extract the load result from the returning bus word
    always_comb begin
        w_st  = (xopc == OPC_STORE);
        w_mem = (xopc == OPC_LOAD) | w_st;
        w_mis = ((xfn3[13:12] == 2'b01) & xadr[0]) | ((xfn3[13:12] == 2'b10) & (|xadr[1:0]));
        w_acc = w_mem & ~w_mis;
        w_sel = (xfn3[13:12] == 2'b00) ? (4'b0001 << xadr[1:0]) :
                (xfn3[13:12] == 2'b01) ? (xadr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_sh  = dwb_dat_i >> {r_lo, 3'b000};
        w_hw  = r_lo[1] ? dwb_dat_i[31:16] : dwb_dat_i[15:0];
        w_ext = (r_fn3[13:12] == 2'b00) ? {{24{~r_fn3[14] & w_sh[7]}}, w_sh[7:0]} :
                (r_fn3[13:12] == 2'b01) ? {{16{~r_fn3[14] & w_hw[15]}}, w_hw} : dwb_dat_i;
    end

    // Next state: an accepted access in IDLE starts a bus cycle, an ack in BUSY ends it
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && sena && w_acc)
            w_next = BUSY;
        else if (r_state == BUSY && dwb_ack_i)
            w_next = IDLE;
    end

    // State register
    always_ff @(posedge sclk) begin
        if (srst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Registered bus outputs, exception status and load result
    always_ff @(posedge sclk) begin
        if (srst) begin
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            dwb_sel_o <= 4'h0;
            dwb_adr_o <= 30'h0;
            dwb_dat_o <= 32'h0;
            mlsu      <= 32'h0;
            xstb      <= 2'b00;
            xwre      <= 1'b0;
            r_fn3     <= 3'b000;
            r_lo      <= 2'b00;
        end else if (r_state == IDLE) begin
            if (sena) begin
                xstb <= {w_mem, w_mem & w_mis};
                if (w_mem)
                    xwre <= w_st;
                if (w_acc) begin
                    dwb_stb_o <= 1'b1;
                    dwb_we_o  <= w_st;
                    dwb_sel_o <= w_sel;
                    dwb_adr_o <= xadr[31:2];
                    dwb_dat_o <= xdat;
                    r_fn3     <= xfn3;
                    r_lo      <= xadr[1:0];
                end
            end
        end else if (dwb_ack_i) begin
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            if (!dwb_we_o)
                mlsu <= w_ext;
        end
    end

    assign lstall = (r_state == BUSY);
endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: directed and randomized checks of t5_lsu against a transaction-level reference model
module tb_t5_lsu;
    logic        sclk = 1'b0;
    logic        srst, sena, dwb_ack_i;
    logic [6:2]  xopc;
    logic [14:12] xfn3;
    logic [31:0] xadr, xdat, dwb_dat_i;
    logic [31:2] dwb_adr_o;
    logic [31:0] dwb_dat_o, mlsu;
    logic [3:0]  dwb_sel_o;
    logic        dwb_we_o, dwb_stb_o, xwre, lstall;
    logic [1:0]  xstb;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:2] LOAD  = 5'b00000;
    localparam logic [6:2] STORE = 5'b01000;
    localparam logic [6:2] OP    = 5'b01100;

    t5_lsu dut (
        .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3),
        .xadr(xadr), .xdat(xdat), .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o),
        .dwb_sel_o(dwb_sel_o), .dwb_we_o(dwb_we_o), .dwb_stb_o(dwb_stb_o),
        .dwb_ack_i(dwb_ack_i), .dwb_dat_i(dwb_dat_i), .mlsu(mlsu), .xstb(xstb),
        .xwre(xwre), .lstall(lstall)
    );

    always #5 sclk = ~sclk;

    // Reference model: one outstanding request plus the architectural results
    bit          m_busy;
    bit          m_we;
    logic [31:0] m_addr, m_wdat, m_mlsu;
    logic [3:0]  m_sel;
    logic [2:0]  m_fn3;
    logic [1:0]  m_xstb;
    bit          m_xwre;

    function automatic logic [3:0] lanes(input logic [2:0] f, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        if (f[1:0] == 2'b00) return 4'(1 << lo);
        if (f[1:0] == 2'b01) return (lo >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] v;
        if (f[1:0] == 2'b00) begin
            v = (d >> (8 * int'(a))) & 32'hFF;
            if (!f[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (f[1:0] == 2'b01) begin
            v = (d >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!f[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else
            v = d;
        return v;
    endfunction

    task automatic model_edge();
        bit mem, mis, st;
        int sz;
        if (srst) begin
            m_busy = 0; m_we = 0; m_addr = 0; m_wdat = 0; m_mlsu = 0;
            m_sel = 0; m_xstb = 0; m_xwre = 0; m_fn3 = 0;
        end else if (!m_busy) begin
            if (sena) begin
                st  = (xopc == STORE);
                mem = st || (xopc == LOAD);
                sz  = (xfn3[13:12] == 2'b00) ? 1 : (xfn3[13:12] == 2'b01) ? 2 : (xfn3[13:12] == 2'b10) ? 4 : 1;
                mis = (xadr % sz) != 0;
                m_xstb = {mem, mem && mis};
                if (mem) m_xwre = st;
                if (mem && !mis) begin
                    m_busy = 1; m_we = st; m_addr = xadr; m_wdat = xdat;
                    m_sel = lanes(xfn3, xadr); m_fn3 = xfn3;
                end
            end
        end else if (dwb_ack_i) begin
            if (!m_we) m_mlsu = extract(m_fn3, m_addr[1:0], dwb_dat_i);
            m_busy = 0; m_we = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("stb",    32'(dwb_stb_o), 32'(m_busy));
        chk("lstall", 32'(lstall),    32'(m_busy));
        chk("xstb",   32'(xstb),      32'(m_xstb));
        chk("xwre",   32'(xwre),      32'(m_xwre));
        chk("mlsu",   mlsu,           m_mlsu);
        if (m_busy) begin
            chk("we",  32'(dwb_we_o),  32'(m_we));
            chk("sel", 32'(dwb_sel_o), 32'(m_sel));
            chk("adr", 32'(dwb_adr_o), 32'(m_addr[31:2]));
            chk("dat", dwb_dat_o,      m_wdat);
        end else
            chk("we_idle", 32'(dwb_we_o), 32'h0);
    endtask

    task automatic step();
        @(posedge sclk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic quiet();
        srst = 0; sena = 1; xopc = OP; xfn3 = 3'b000; xadr = 0; xdat = 0;
        dwb_ack_i = 0; dwb_dat_i = 0;
    endtask

    task automatic issue(input logic [6:2] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        sena = 1; xopc = o; xfn3 = f; xadr = a; xdat = d;
        step();
        sena = 0; xopc = OP;
    endtask

    task automatic complete(input int waits, input logic [31:0] rd, output int n_stb, output int n_stall);
        n_stb = 0; n_stall = 0;
        for (int i = 0; i <= waits; i++) begin
            if (dwb_stb_o) n_stb++;
            if (lstall) n_stall++;
            dwb_ack_i = (i == waits);
            dwb_dat_i = rd;
            step();
        end
        dwb_ack_i = 0;
        sena = 1;
    endtask

    initial begin
        int ns, nl;
        quiet();
        srst = 1;
        step();
        step();
        chk("rst_stb", 32'(dwb_stb_o), 32'h0);
        chk("rst_sel", 32'(dwb_sel_o), 32'h0);
        chk("rst_adr", 32'(dwb_adr_o), 32'h0);
        chk("rst_dat", dwb_dat_o, 32'h0);
        chk("rst_mlsu", mlsu, 32'h0);
        chk("rst_xstb", 32'(xstb), 32'h0);
        chk("rst_stall", 32'(lstall), 32'h0);
        quiet();
        step();

        issue(LOAD, 3'b010, 32'h100, 32'h0);
        chk("lw_sel", 32'(dwb_sel_o), 32'hF);
        chk("lw_adr", 32'(dwb_adr_o), 32'h40);
        chk("lw_xstb", 32'(xstb), 32'h2);
        chk("lw_xwre", 32'(xwre), 32'h0);
        complete(3, 32'hDEADBEEF, ns, nl);
        chk("lw_stb_cycles", 32'(ns), 32'd4);
        chk("lw_stall_cycles", 32'(nl), 32'd4);
        chk("lw_mlsu", mlsu, 32'hDEADBEEF);
        chk("lw_stall_done", 32'(lstall), 32'h0);

        issue(LOAD, 3'b000, 32'h203, 32'h0);
        chk("lb_sel", 32'(dwb_sel_o), 32'h8);
        complete(1, 32'h80123456, ns, nl);
        chk("lb_mlsu", mlsu, 32'hFFFFFF80);
        issue(LOAD, 3'b100, 32'h203, 32'h0);
        complete(0, 32'h80123456, ns, nl);
        chk("lbu_mlsu", mlsu, 32'h00000080);

        issue(STORE, 3'b001, 32'h302, 32'hA5A5A5A5);
        chk("sh_we", 32'(dwb_we_o), 32'h1);
        chk("sh_sel", 32'(dwb_sel_o), 32'hC);
        chk("sh_dat", dwb_dat_o, 32'hA5A5A5A5);
        chk("sh_xwre", 32'(xwre), 32'h1);
        complete(0, 32'h11111111, ns, nl);
        chk("sh_stb_cycles", 32'(ns), 32'd1);
        chk("sh_mlsu_kept", mlsu, 32'h00000080);

        issue(STORE, 3'b010, 32'h401, 32'h0);
        chk("mis_stb", 32'(dwb_stb_o), 32'h0);
        chk("mis_xstb", 32'(xstb), 32'h3);
        chk("mis_xwre", 32'(xwre), 32'h1);
        chk("mis_stall", 32'(lstall), 32'h0);
        sena = 1; xopc = OP;
        step();
        chk("add_xstb", 32'(xstb), 32'h0);
        chk("add_xwre", 32'(xwre), 32'h1);

        issue(LOAD, 3'b010, 32'h500, 32'h0);
        step();
        srst = 1;
        step();
        chk("rma_stb", 32'(dwb_stb_o), 32'h0);
        chk("rma_stall", 32'(lstall), 32'h0);
        chk("rma_mlsu", mlsu, 32'h0);
        srst = 0; dwb_ack_i = 1; dwb_dat_i = 32'h12345678;
        step();
        dwb_ack_i = 0;
        chk("late_ack_mlsu", mlsu, 32'h0);
        chk("late_ack_stb", 32'(dwb_stb_o), 32'h0);
        issue(LOAD, 3'b010, 32'h104, 32'h0);
        complete(1, 32'hCAFEF00D, ns, nl);
        chk("post_rst_lw", mlsu, 32'hCAFEF00D);

        issue(LOAD, 3'b010, 32'h108, 32'h0);
        srst = 1; dwb_ack_i = 1; dwb_dat_i = 32'hFFFFFFFF;
        step();
        chk("rst_vs_ack", mlsu, 32'h0);
        quiet();
        step();

        for (int i = 0; i < 1500; i++) begin
            int r;
            srst = ($urandom_range(0, 79) == 0);
            sena = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 4);
            xopc = (r < 2) ? LOAD : (r < 4) ? STORE : 5'($urandom);
            xfn3 = 3'($urandom);
            xadr = $urandom;
            xdat = $urandom;
            dwb_ack_i = ($urandom_range(0, 2) == 0);
            dwb_dat_i = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
